// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

  // Largest requester count the arbiter is built for.
  localparam int MAX_REQ = 8;

  typedef logic [7:0] byte_t;

  // IDLE: no owner. SEND: byte presented to the transmitter.
  // HOLD: owner keeps the lock between bytes of one message.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr_i,
// wrapping from N-1 back to 0.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [IW:0] cand;

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found_o && req_i[cand[IW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one strobe/busy UART transmitter among NUM_REQ byte streams.
// Ownership is held for a whole message (until a byte flagged last is sent)
// or until the owner stalls for LOCK_TIMEOUT cycles, so lines never interleave.
//
// Handshakes: a requester byte moves when req_valid_i[k] and req_ready_o[k]
// are both high in a cycle; the requester must hold valid/data/last stable
// until then. Towards the transmitter, a byte moves when tx_stb_o=1 and
// tx_busy_i=0; tx_stb_o/tx_data_o stay stable until that happens.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 tx_stb_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_busy_i,
  output logic                 timeout_o,
  output logic [1:0]           dbg_state_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = (LOCK_TIMEOUT > 0) ? TW'(LOCK_TIMEOUT - 1) : '0;
  localparam logic [IW-1:0] OWNER_MAX  = IW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ out of range");
  end

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  byte_t         data_q, data_d;
  logic          last_q, last_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;

  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] owner_next;
  byte_t         sel_byte;
  logic          take;

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // In IDLE the picker chooses the source; otherwise only the owner is served.
  assign sel_idx    = (state_q == IDLE) ? pick_idx : owner_q;
  assign sel_byte   = req_data_i[8*sel_idx +: 8];
  assign owner_next = (owner_q == OWNER_MAX) ? '0 : owner_q + 1'b1;

  // Next-state logic: arbitration, message lock and stall timeout.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    last_d    = last_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    take      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          take    = 1'b1;
          owner_d = pick_idx;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_busy_i) begin
          if (last_q) begin
            state_d = IDLE;
            ptr_d   = owner_next;
          end else begin
            state_d = HOLD;
            timer_d = '0;
          end
        end
      end
      HOLD: begin
        if (req_valid_i[owner_q]) begin
          take    = 1'b1;
          state_d = SEND;
        end else if (LOCK_TIMEOUT != 0 && timer_q >= TIMER_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          ptr_d     = owner_next;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      data_d = sel_byte;
      last_d = req_last_i[sel_idx];
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      data_q    <= data_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  // Ready depends only on registered state and req_valid_i, never tx_busy_i;
  // it is forced low while reset is held.
  assign req_ready_o = (take && reset_i) ? (NUM_REQ'(1) << sel_idx) : '0;
  assign grant_o     = (state_q != IDLE) ? (NUM_REQ'(1) << owner_q) : '0;
  assign tx_stb_o    = (state_q == SEND);
  assign tx_data_o   = data_q;
  assign timeout_o   = timeout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: message locking, round-robin order,
// stall timeout, transmitter back-pressure and asynchronous reset.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int LT = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]   req_valid_i = '0;
  logic [NR*8-1:0] req_data_i  = '0;
  logic [NR-1:0]   req_last_i  = '0;
  logic [NR-1:0]   req_ready_o;
  logic [NR-1:0]   grant_o;
  logic            tx_stb_o;
  logic [7:0]      tx_data_o;
  logic            tx_busy_i = 1'b0;
  logic            timeout_o;
  logic [1:0]      dbg_state_o;

  uart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(LT)) dut (
    .clk_i       (clk),
    .reset_i     (rst_n),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .grant_o     (grant_o),
    .tx_stb_o    (tx_stb_o),
    .tx_data_o   (tx_data_o),
    .tx_busy_i   (tx_busy_i),
    .timeout_o   (timeout_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  // Per-requester byte sources: {last, data}
  logic [8:0] src_mem [NR][16];
  int src_wr [NR] = '{default: 0};
  int src_rd [NR] = '{default: 0};

  int   busy_after = 0;
  int   busy_left  = 0;
  logic force_busy = 1'b0;

  // ---------------- driver tasks ----------------
  task automatic drive_src();
    for (int k = 0; k < NR; k++) begin
      if (src_rd[k] < src_wr[k]) begin
        req_valid_i[k]       = 1'b1;
        req_data_i[8*k +: 8] = src_mem[k][src_rd[k] % 16][7:0];
        req_last_i[k]        = src_mem[k][src_rd[k] % 16][8];
      end else begin
        req_valid_i[k]       = 1'b0;
        req_data_i[8*k +: 8] = 8'h00;
        req_last_i[k]        = 1'b0;
      end
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    src_mem[k][src_wr[k] % 16] = {l, d};
    src_wr[k]++;
  endtask

  // Advance to the sampling point of the next cycle (mid low phase).
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Requesters pop on handshake; transmitter model goes busy after accepts.
  always @(posedge clk) begin
    for (int k = 0; k < NR; k++)
      if (req_ready_o[k] && req_valid_i[k]) src_rd[k]++;
    if (tx_stb_o && !tx_busy_i) busy_left = busy_after;
    else if (busy_left > 0) busy_left--;
    #1;
    drive_src();
    tx_busy_i = force_busy || (busy_left > 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the transmitter to accept a byte, check it, then
  // move on to the following cycle.
  task automatic wait_accept(input string tag, input logic [NR-1:0] g);
    int n;
    logic [7:0] e;
    n = 0;
    e = exp_q.pop_front();
    while (!(tx_stb_o && !tx_busy_i) && n < 300) begin
      step();
      n++;
    end
    check({tag, " wait"}, 32'(n >= 300), 32'd0);
    check({tag, " data"}, {24'd0, tx_data_o}, {24'd0, e});
    check({tag, " grant"}, {28'd0, grant_o}, {28'd0, g});
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) step();
    check("reset outputs", {grant_o, req_ready_o, tx_stb_o, tx_data_o, timeout_o, dbg_state_o},
          32'd0);
    rst_n = 1'b1;
    step();
    step();

    // Single requester "Hi\n", transmitter busy 10 cycles after each byte
    busy_after = 10;
    push(0, 8'h48, 1'b0);
    push(0, 8'h69, 1'b0);
    push(0, 8'h0A, 1'b1);
    drive_src();
    #1;
    check("t1 ready same cycle", {28'd0, req_ready_o}, 32'h1);
    check("t1 no strobe yet", {31'd0, tx_stb_o}, 32'd0);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h69);
    exp_q.push_back(8'h0A);
    step();
    check("t1 strobe next cycle", {23'd0, tx_stb_o, tx_data_o}, {23'd0, 1'b1, 8'h48});
    wait_accept("t1 H", 4'b0001);
    wait_accept("t1 i", 4'b0001);
    wait_accept("t1 nl", 4'b0001);
    check("t1 idle after last", {28'd0, dbg_state_o, grant_o[1:0]}, 32'd0);
    check("t1 grant zero", {28'd0, grant_o}, 32'd0);

    // Requesters 1 and 2 valid from reset release: no interleave
    busy_after = 2;
    rst_n = 1'b0;
    push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b0); push(1, 8'h13, 1'b1);
    push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b1);
    drive_src();
    #1;
    check("t2 ready held in reset", {28'd0, req_ready_o}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("t2 first pick", {28'd0, req_ready_o}, 32'h2);
    exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h13);
    exp_q.push_back(8'h21); exp_q.push_back(8'h22); exp_q.push_back(8'h23);
    wait_accept("t2 r1b0", 4'b0010);
    wait_accept("t2 r1b1", 4'b0010);
    wait_accept("t2 r1b2", 4'b0010);
    wait_accept("t2 r2b0", 4'b0100);
    wait_accept("t2 r2b1", 4'b0100);
    wait_accept("t2 r2b2", 4'b0100);

    // Pointer is 3: requester 3 beats requester 1
    push(1, 8'h31, 1'b1);
    push(3, 8'h33, 1'b1);
    drive_src();
    #1;
    check("t3 pointer at 3", {28'd0, req_ready_o}, 32'h8);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h31);
    wait_accept("t3 r3", 4'b1000);
    wait_accept("t3 r1", 4'b0010);
    push(3, 8'h43, 1'b1);
    drive_src();
    exp_q.push_back(8'h43);
    wait_accept("t3 r3 alone", 4'b1000);
    // Requester 3 finished: pointer wraps to 0
    push(0, 8'h50, 1'b1);
    push(3, 8'h53, 1'b1);
    drive_src();
    #1;
    check("t3 wrap pick", {28'd0, req_ready_o}, 32'h1);
    exp_q.push_back(8'h50);
    exp_q.push_back(8'h53);
    wait_accept("t3 r0", 4'b0001);
    wait_accept("t3 r3 second", 4'b1000);

    // Owner 1 stalls after first byte, requester 2 waiting
    busy_after = 0;
    push(1, 8'h61, 1'b0);
    push(2, 8'h62, 1'b1);
    drive_src();
    #1;
    check("t4 owner pick", {28'd0, req_ready_o}, 32'h2);
    exp_q.push_back(8'h61);
    wait_accept("t4 r1b0", 4'b0010);
    for (int i = 0; i < LT; i++) begin
      check($sformatf("t4 hold cycle %0d", i), {23'd0, timeout_o, grant_o, req_ready_o},
            {23'd0, 1'b0, 4'b0010, 4'b0000});
      step();
    end
    check("t4 timeout pulse", {23'd0, timeout_o, grant_o, req_ready_o},
          {23'd0, 1'b1, 4'b0000, 4'b0100});
    exp_q.push_back(8'h62);
    step();
    check("t4 r2 granted", {23'd0, timeout_o, grant_o, tx_stb_o, 3'd0},
          {23'd0, 1'b0, 4'b0100, 1'b1, 3'd0});
    wait_accept("t4 r2", 4'b0100);

    // Transmitter busy 50 cycles during SEND, non-owner valid waiting
    force_busy = 1'b1;
    tx_busy_i  = 1'b1;
    push(0, 8'h70, 1'b1);
    drive_src();
    #1;
    check("t5 pick wraps to 0", {28'd0, req_ready_o}, 32'h1);
    step();
    push(3, 8'h73, 1'b1);
    drive_src();
    #1;
    for (int i = 0; i < 50; i++) begin
      check($sformatf("t5 stable cycle %0d", i), {19'd0, tx_stb_o, tx_data_o, req_ready_o},
            {19'd0, 1'b1, 8'h70, 4'b0000});
      step();
    end
    force_busy = 1'b0;
    tx_busy_i  = 1'b0;
    exp_q.push_back(8'h70);
    exp_q.push_back(8'h73);
    wait_accept("t5 r0", 4'b0001);
    wait_accept("t5 r3", 4'b1000);

    // Reset asserted mid-SEND
    force_busy = 1'b1;
    tx_busy_i  = 1'b1;
    push(1, 8'h80, 1'b1);
    drive_src();
    #1;
    check("t6 pick", {28'd0, req_ready_o}, 32'h2);
    step();
    check("t6 in send", {23'd0, tx_stb_o, tx_data_o}, {23'd0, 1'b1, 8'h80});
    rst_n = 1'b0;
    #1;
    check("t6 async reset outputs",
          {grant_o, req_ready_o, tx_stb_o, tx_data_o, timeout_o, dbg_state_o}, 32'd0);
    step();
    step();
    force_busy = 1'b0;
    tx_busy_i  = 1'b0;
    rst_n = 1'b1;
    #1;
    check("t6 no strobe after release", {31'd0, tx_stb_o}, 32'd0);
    step();
    check("t6 still idle", {30'd0, dbg_state_o}, 32'd0);
    push(0, 8'h90, 1'b1);
    drive_src();
    #1;
    check("t6 first valid ready", {28'd0, req_ready_o}, 32'h1);
    exp_q.push_back(8'h90);
    wait_accept("t6 r0", 4'b0001);
    check("t6 idle at end", {28'd0, grant_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
